// File: rtl/noc_xbar_rr.sv
// NPORTS x NPORTS crossbar with per-output round-robin arbitration and a 1-deep output register.
// Latency 1 cycle input->output; an output with a held flit and out_ready low stalls its requesters.
module noc_xbar_rr #(
  parameter int NPORTS = 7,
  parameter int DW     = 20,
  localparam int TW    = $clog2(NPORTS + 1),
  localparam int SW    = $clog2(NPORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*(DW+TW)-1:0] in_data,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  input  logic [NPORTS-1:0]        cb_en,
  output logic [NPORTS*DW-1:0]     out_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [NPORTS*SW-1:0]     out_src,
  output logic [NPORTS-1:0]        err_drop
);

  localparam int FW = DW + TW;

  logic [TW-1:0]     dest    [NPORTS];
  logic [DW-1:0]     payload [NPORTS];
  logic [SW-1:0]     ptr     [NPORTS];
  logic [SW-1:0]     win     [NPORTS];
  logic [NPORTS-1:0] win_vld;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] in_grant;
  logic [NPORTS-1:0] bad_dest;

  always_comb begin : unpack
    for (int i = 0; i < NPORTS; i++) begin
      dest[i]     = in_data[i*FW +: TW];
      payload[i]  = in_data[i*FW+TW +: DW];
      bad_dest[i] = in_valid[i] & cb_en[i] & ((dest[i] == '0) | (int'(dest[i]) > NPORTS));
    end
  end

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin : arb
    int            idx;
    logic          found;
    logic [SW-1:0] w;
    for (int o = 0; o < NPORTS; o++) begin
      found = 1'b0;
      w     = '0;
      for (int k = 0; k < NPORTS; k++) begin
        idx = int'(ptr[o]) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (!found && in_valid[idx] && cb_en[idx] && (int'(dest[idx]) == o + 1)) begin
          found = 1'b1;
          w     = SW'(idx);
        end
      end
      win[o]     = w;
      win_vld[o] = found;
      grant[o]   = found & (~out_valid[o] | out_ready[o]);
    end
  end

  always_comb begin : ready_map
    logic acc;
    for (int i = 0; i < NPORTS; i++) begin
      acc = 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
        acc = acc | (grant[o] & (win[o] == SW'(i)));
      end
      in_grant[i] = acc;
    end
  end

  assign in_ready = rst ? '0 : (in_grant | bad_dest);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
      err_drop  <= '0;
      for (int o = 0; o < NPORTS; o++) ptr[o] <= '0;
    end else begin
      err_drop <= bad_dest;
      for (int o = 0; o < NPORTS; o++) begin
        if (grant[o]) begin
          out_valid[o]          <= 1'b1;
          out_data[o*DW +: DW]  <= payload[win[o]];
          out_src[o*SW +: SW]   <= win[o];
          ptr[o]                <= (win[o] == SW'(NPORTS - 1)) ? '0 : win[o] + SW'(1);
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

endmodule
